// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin sequencer for the 32x32 data memory (read port A + write port).
// Optional out-of-range checking is compiled in with the ARB_BOUNDS_EN macro.
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              err0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              err1_o,
    output logic [31:0]       mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return 32'(a) >= 32'(DEPTH);
    endfunction

    function automatic logic [31:0] zext_addr(input logic [ADDR_W-1:0] a);
        return 32'(a);
    endfunction

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_p0, owner_d;
    logic                we_p0, we_d;
    logic                err_p0, err_d;
    logic [DATA_W-1:0]   wdata_p0, wdata_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;

    logic                pick;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                oob;

    // Grant selection: contention alternates against last_grant; a lone requester always wins.
    always_comb begin
        pick      = (req0_i && req1_i) ? ~last_q : req1_i;
        sel_we    = pick ? we1_i    : we0_i;
        sel_addr  = pick ? addr1_i  : addr0_i;
        sel_wdata = pick ? wdata1_i : wdata0_i;
`ifdef ARB_BOUNDS_EN
        oob       = out_of_range(sel_addr);
`else
        oob       = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_p0;
        we_d        = we_p0;
        err_d       = err_p0;
        wdata_d     = wdata_p0;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    state_d     = ACCESS;
                    last_d      = pick;
                    owner_d     = pick;
                    we_d        = sel_we;
                    err_d       = oob;
                    wdata_d     = sel_wdata;
                    mem_addr_d  = zext_addr(sel_addr);
                    mem_read_d  = !sel_we && !oob;
                    mem_write_d = sel_we && !oob;
                end
            end
            ACCESS: begin
                // Read data is captured by the memory at the edge ending ACCESS, so ack lines up with it.
                state_d = RESP;
                ack0_d  = !owner_p0;
                ack1_d  = owner_p0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_p0    <= 1'b0;
            we_p0       <= 1'b0;
            err_p0      <= 1'b0;
            wdata_p0    <= '0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_p0    <= owner_d;
            we_p0       <= we_d;
            err_p0      <= err_d;
            wdata_p0    <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = wdata_p0;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_p0;
    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    // Read data is only forwarded during the owner's ack of a valid read; otherwise held at zero.
    assign rdata0_o    = (ack0_q && !we_p0 && !err_p0) ? mem_rdata_i : '0;
    assign rdata1_o    = (ack1_q && !we_p0 && !err_p0) ? mem_rdata_i : '0;
`ifdef ARB_BOUNDS_EN
    assign err0_o      = ack0_q && err_p0;
    assign err1_o      = ack1_q && err_p0;
`else
    assign err0_o      = 1'b0;
    assign err1_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 32x32 memory (registered read A, negedge write).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy, owner;
  logic        preload;
  logic [31:0] mem [0:31];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DEPTH(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .ack0_o(ack0), .rdata0_o(rdata0), .err0_o(err0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .ack1_o(ack1), .rdata1_o(rdata1), .err1_o(err1),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_o(owner)
  );

  always @(posedge clk)
    if (mem_read) mem_rdata <= (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
    end else if (mem_write && mem_addr < 32) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_ack0", 32'(ack0), 32'(1'b0));
    chk("rst_ack1", 32'(ack1), 32'(1'b0));
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_owner", 32'(owner), 32'(1'b0));
    chk("rst_mem_read", 32'(mem_read), 32'(1'b0));
    chk("rst_mem_write", 32'(mem_write), 32'(1'b0));
    chk("rst_rdata0", rdata0, 32'h0);
    reset = 1'b0; preload = 1'b0;
    step();

    // 1: requester 0 reads addr 5
    req0 = 1; we0 = 0; addr0 = 8'd5;
    step();
    chk("t1_mem_read", 32'(mem_read), 32'(1'b1));
    chk("t1_mem_addr", mem_addr, 32'd5);
    chk("t1_busy", 32'(busy), 32'(1'b1));
    chk("t1_owner", 32'(owner), 32'(1'b0));
    chk("t1_ack0_early", 32'(ack0), 32'(1'b0));
    req0 = 0;
    step();
    chk("t1_ack0", 32'(ack0), 32'(1'b1));
    chk("t1_rdata0", rdata0, 32'd5);
    chk("t1_ack1", 32'(ack1), 32'(1'b0));
    chk("t1_rdata1", rdata1, 32'h0);
    chk("t1_mem_read_resp", 32'(mem_read), 32'(1'b0));
    step();
    chk("t1_idle_busy", 32'(busy), 32'(1'b0));
    chk("t1_idle_ack0", 32'(ack0), 32'(1'b0));
    chk("t1_idle_rdata0", rdata0, 32'h0);

    // 2: requester 1 writes addr 3 then reads it back
    req1 = 1; we1 = 1; addr1 = 8'd3; wdata1 = 32'hDEADBEEF;
    step();
    chk("t2_mem_write", 32'(mem_write), 32'(1'b1));
    chk("t2_mem_read", 32'(mem_read), 32'(1'b0));
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t2_owner", 32'(owner), 32'(1'b1));
    chk("t2_ack0_a", 32'(ack0), 32'(1'b0));
    req1 = 0;
    step();
    chk("t2_ack1_w", 32'(ack1), 32'(1'b1));
    chk("t2_mem_write_resp", 32'(mem_write), 32'(1'b0));
    chk("t2_ack0_b", 32'(ack0), 32'(1'b0));
    chk("t2_mem3", mem[3], 32'hDEADBEEF);
    step();
    req1 = 1; we1 = 0; addr1 = 8'd3;
    step();
    chk("t2_rd_mem_read", 32'(mem_read), 32'(1'b1));
    chk("t2_ack0_c", 32'(ack0), 32'(1'b0));
    req1 = 0;
    step();
    chk("t2_ack1_r", 32'(ack1), 32'(1'b1));
    chk("t2_rdata1", rdata1, 32'hDEADBEEF);
    chk("t2_ack0_d", 32'(ack0), 32'(1'b0));
    step();

    // 3: both requesters streaming after reset alternate 0,1,0,1,...
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1; we0 = 0; addr0 = 8'd10;
    req1 = 1; we1 = 0; addr1 = 8'd11;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t3_owner", 32'(owner), 32'(k % 2));
      chk("t3_busy", 32'(busy), 32'(1'b1));
      step();
      chk("t3_ack0", 32'(ack0), 32'(k % 2 == 0));
      chk("t3_ack1", 32'(ack1), 32'(k % 2 == 1));
      chk("t3_rdata0", rdata0, (k % 2 == 0) ? 32'd10 : 32'd0);
      chk("t3_rdata1", rdata1, (k % 2 == 1) ? 32'd11 : 32'd0);
      step();
      chk("t3_idle", 32'(busy), 32'(1'b0));
      if (k == 5) begin
        req0 = 0; req1 = 0;
      end
    end

    // 4: reset during ACCESS of a requester-1 read
    req1 = 1; we1 = 0; addr1 = 8'd4;
    step();
    chk("t4_mem_read", 32'(mem_read), 32'(1'b1));
    chk("t4_owner", 32'(owner), 32'(1'b1));
    req1 = 0; reset = 1'b1;
    step();
    chk("t4_ack1", 32'(ack1), 32'(1'b0));
    chk("t4_busy", 32'(busy), 32'(1'b0));
    chk("t4_mem_read_rst", 32'(mem_read), 32'(1'b0));
    chk("t4_mem_addr_rst", mem_addr, 32'h0);
    chk("t4_rdata1", rdata1, 32'h0);
    reset = 1'b0;
    step();
    chk("t4_ack1_after", 32'(ack1), 32'(1'b0));
    req0 = 1; we0 = 0; addr0 = 8'd6;
    req1 = 1; we1 = 0; addr1 = 8'd9;
    step();
    chk("t4_grant0", 32'(owner), 32'(1'b0));
    req0 = 0; req1 = 0;
    step();
    chk("t4_ack0", 32'(ack0), 32'(1'b1));
    chk("t4_rdata0", rdata0, 32'd6);
    step();

    // 5: out-of-range address 40
`ifdef ARB_BOUNDS_EN
    req0 = 1; we0 = 1; addr0 = 8'd40; wdata0 = 32'h1234;
    step();
    chk("t5_mem_write", 32'(mem_write), 32'(1'b0));
    chk("t5_mem_read", 32'(mem_read), 32'(1'b0));
    chk("t5_mem_addr", mem_addr, 32'd40);
    req0 = 0;
    step();
    chk("t5_ack0", 32'(ack0), 32'(1'b1));
    chk("t5_err0", 32'(err0), 32'(1'b1));
    chk("t5_rdata0", rdata0, 32'h0);
    step();
`else
    req0 = 1; we0 = 0; addr0 = 8'd40;
    step();
    chk("t5_mem_read", 32'(mem_read), 32'(1'b1));
    chk("t5_mem_addr", mem_addr, 32'd40);
    req0 = 0;
    step();
    chk("t5_ack0", 32'(ack0), 32'(1'b1));
    chk("t5_err0", 32'(err0), 32'(1'b0));
    chk("t5_rdata0", rdata0, 32'h0);
    step();
`endif
    req0 = 1; we0 = 0; addr0 = 8'd8;
    step();
    req0 = 0;
    step();
    chk("t5_rd8_ack0", 32'(ack0), 32'(1'b1));
    chk("t5_rd8_err0", 32'(err0), 32'(1'b0));
    chk("t5_rd8_rdata0", rdata0, 32'd8);
    step();

    // 6: requester 0 drops req during ACCESS of a write to addr 7
    req0 = 1; we0 = 1; addr0 = 8'd7; wdata0 = 32'hA5A5;
    step();
    req0 = 0; addr0 = 8'd0; wdata0 = 32'h0;
    chk("t6_mem_write", 32'(mem_write), 32'(1'b1));
    chk("t6_mem_addr", mem_addr, 32'd7);
    step();
    chk("t6_ack0", 32'(ack0), 32'(1'b1));
    chk("t6_mem7", mem[7], 32'hA5A5);
    step();
    chk("t6_idle", 32'(busy), 32'(1'b0));
    step();
    chk("t6_stay_idle", 32'(busy), 32'(1'b0));
    chk("t6_no_ack", 32'(ack0), 32'(1'b0));
    req0 = 1; we0 = 0; addr0 = 8'd7;
    step();
    req0 = 0;
    step();
    chk("t6_readback", rdata0, 32'hA5A5);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
